// File: rtl/freq_meter_10mhz.sv
// Gated frequency counter: counts SIG_IN rising edges over GATE_CYCLES master-clock cycles.
// Optional FREQ_METER_BCD_EN adds a FREQ_BCD output fed by an iterative shift-add-3 converter.
module freq_meter_10mhz #(
  parameter int GATE_CYCLES = 10000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_10MHz,
  input  logic             RESET,
  input  logic             SIG_IN,
  input  logic             START,
  input  logic             CONTINUOUS,
  output logic [CNT_W-1:0] FREQ_COUNT,
  output logic             COUNT_VALID,
  output logic             BUSY,
  output logic             OVERFLOW
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [31:0]      FREQ_BCD
`endif
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // state | meaning
  // IDLE  | waiting for START
  // ARM   | clear edge counter, load gate timer
  // GATE  | counting edges for GATE_CYCLES cycles
  // DONE  | latch result (or start BCD conversion)
  // CONV  | shift-add-3 conversion, one bit per cycle (BCD build only)
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] GATE = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
`ifdef FREQ_METER_BCD_EN
  localparam logic [2:0] CONV = 3'd4;
  localparam int BW = $clog2(CNT_W + 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [SS-1:0]    sync_q, sync_d;
  logic             dly_q, dly_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             edge_pulse;
`ifdef FREQ_METER_BCD_EN
  logic [CNT_W-1:0] bin_q, bin_d;
  logic [31:0]      work_q, work_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [31:0]      work_adj;
  logic [31:0]      work_step;
`endif

  assign sync_d     = {sync_q[SS-2:0], SIG_IN};
  assign dly_d      = sync_q[SS-1];
  assign edge_pulse = sync_q[SS-1] & ~dly_q;

`ifdef FREQ_METER_BCD_EN
  // Add 3 to every digit >= 5, then shift the next binary bit in.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 8; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    work_step = {work_adj[30:0], bin_q[CNT_W-1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
`ifdef FREQ_METER_BCD_EN
    bin_d   = bin_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) state_d = ARM;
      end
      ARM: begin
        cnt_d   = '0;
        sat_d   = 1'b0;
        gate_d  = GATE_LOAD;
        state_d = GATE;
      end
      GATE: begin
        if (edge_pulse) begin
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        if (gate_q == '0) state_d = DONE;
        else              gate_d  = gate_q - GW'(1);
      end
      DONE: begin
`ifdef FREQ_METER_BCD_EN
        bin_d   = cnt_q;
        work_d  = '0;
        bit_d   = BW'(CNT_W);
        state_d = CONV;
`else
        freq_d  = cnt_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        state_d = CONTINUOUS ? ARM : IDLE;
`endif
      end
`ifdef FREQ_METER_BCD_EN
      CONV: begin
        // cnt_q/sat_q are untouched until the next ARM, so they are latched here
        work_d = work_step;
        bin_d  = {bin_q[CNT_W-2:0], 1'b0};
        bit_d  = bit_q - BW'(1);
        if (bit_q == BW'(1)) begin
          freq_d  = cnt_q;
          ovf_d   = sat_q;
          bcd_d   = work_step;
          valid_d = 1'b1;
          state_d = CONTINUOUS ? ARM : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef FREQ_METER_BCD_EN
  assign busy_d = (state_d == ARM) || (state_d == GATE) || (state_d == CONV);
`else
  assign busy_d = (state_d == ARM) || (state_d == GATE);
`endif

  always_ff @(posedge CLOCK_10MHz) begin
    if (RESET) begin
      state_q <= IDLE;
      sync_q  <= '0;
      dly_q   <= 1'b0;
      gate_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FREQ_METER_BCD_EN
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef FREQ_METER_BCD_EN
      bin_q   <= bin_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
`endif
    end
  end

  assign FREQ_COUNT  = freq_q;
  assign COUNT_VALID = valid_q;
  assign BUSY        = busy_q;
  assign OVERFLOW    = ovf_q;
`ifdef FREQ_METER_BCD_EN
  assign FREQ_BCD    = bcd_q;
`endif

endmodule

// File: tb/tb_freq_meter_10mhz.sv
// Self-checking bench for freq_meter_10mhz: vector table plus scoreboard of expected results.
// Also covers the FREQ_METER_BCD_EN build when that macro is defined.
module tb_freq_meter_10mhz;
  localparam int G = 100;
  localparam int W = 5;
`ifdef FREQ_METER_BCD_EN
  localparam int EXTRA = W;
`else
  localparam int EXTRA = 0;
`endif
  // cycles from the negedge START is driven to the negedge COUNT_VALID is seen
  localparam int LAT    = G + 3 + EXTRA;
  localparam int PERIOD = G + 2 + EXTRA;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig = 1'b0;
  logic         start = 1'b0;
  logic         cont = 1'b0;
  logic [W-1:0] freq_count;
  logic         count_valid;
  logic         busy;
  logic         overflow;
`ifdef FREQ_METER_BCD_EN
  logic [31:0]  freq_bcd;
`endif

  freq_meter_10mhz #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(2)) dut (
    .CLOCK_10MHz (clk),
    .RESET       (rst),
    .SIG_IN      (sig),
    .START       (start),
    .CONTINUOUS  (cont),
    .FREQ_COUNT  (freq_count),
    .COUNT_VALID (count_valid),
    .BUSY        (busy),
    .OVERFLOW    (overflow)
`ifdef FREQ_METER_BCD_EN
    ,
    .FREQ_BCD    (freq_bcd)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit ovf;
    int due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int period;
    bit static_val;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  int gen_per = 0;
  bit gen_static = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int to_bcd(int v);
    int r = 0;
    for (int d = 0; d < 8; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  // SIG_IN generator: square wave of gen_per cycles (high for gen_per/2), or static level
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      if (gen_per == 0) sig = gen_static;
      else begin
        if (ph >= gen_per) ph = 0;
        sig = (ph < gen_per / 2);
        ph  = ph + 1;
        if (ph >= gen_per) ph = 0;
      end
    end
  end

  // scoreboard consumer
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && count_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("freq_count", int'(freq_count), e.cnt);
          chk("overflow", int'(overflow), int'(e.ovf));
          chk("valid_cycle", cyc, e.due);
`ifdef FREQ_METER_BCD_EN
          chk("freq_bcd", int'(freq_bcd), to_bcd(e.cnt));
`endif
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic set_sig(input int per, input bit sv);
    gen_per    = per;
    gen_static = sv;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one(input vec_t v);
    exp_t e;
    set_sig(v.period, v.static_val);
    e.cnt = v.exp_cnt;
    e.ovf = v.exp_ovf;
    e.due = cyc + LAT;
    sb.push_back(e);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("busy_in_gate", int'(busy), 1);
    wait_drain(LAT + 20);
    repeat (5) @(negedge clk);
    chk("count_hold", int'(freq_count), v.exp_cnt);
    chk("ovf_hold", int'(overflow), int'(v.exp_ovf));
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int c0;
    exp_t e;
    vecs[0] = '{10, 1'b0, 10, 1'b0};
    vecs[1] = '{4,  1'b0, 25, 1'b0};
    vecs[2] = '{20, 1'b0, 5,  1'b0};
    vecs[3] = '{0,  1'b1, 0,  1'b0};
    vecs[4] = '{0,  1'b0, 0,  1'b0};
    vecs[5] = '{2,  1'b0, 31, 1'b1};
    vecs[6] = '{20, 1'b0, 5,  1'b0};
    vecs[7] = '{5,  1'b0, 20, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_freq_count", int'(freq_count), 0);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);

    for (int i = 0; i < 8; i++) run_one(vecs[i]);

    // START pulses while busy and in DONE are ignored
    set_sig(10, 1'b0);
    c0 = cyc;
    e.cnt = 10; e.ovf = 1'b0; e.due = c0 + LAT;
    sb.push_back(e);
    pulse_start();
    while (cyc < c0 + G + 2) begin
      if (cyc == c0 + 20 || cyc == c0 + 60) pulse_start();
      else @(negedge clk);
    end
    pulse_start();
    wait_drain(LAT + 20);
    repeat (G + 30) @(negedge clk);
    chk("ignored_start_busy", int'(busy), 0);

    // CONTINUOUS alone does not start a measurement
    cont = 1'b1;
    repeat (20) @(negedge clk);
    chk("cont_no_start", int'(busy), 0);

    // continuous mode: fixed result period, then drop CONTINUOUS mid-gate
    set_sig(5, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cnt = 20; e.ovf = 1'b0; e.due = c0 + LAT + k * PERIOD;
      sb.push_back(e);
    end
    pulse_start();
    begin
      int n = 0;
      while (sb.size() > 1 && n < 3 * PERIOD) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (50) @(negedge clk);
    chk("cont_mid_busy", int'(busy), 1);
    cont = 1'b0;
    wait_drain(PERIOD + 20);
    repeat (5) @(negedge clk);
    chk("cont_end_busy", int'(busy), 0);
    repeat (PERIOD + 20) @(negedge clk);

    // reset in the middle of a gate aborts and clears the result
    set_sig(10, 1'b0);
    pulse_start();
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("gate_rst_busy", int'(busy), 0);
    chk("gate_rst_count", int'(freq_count), 0);
    chk("gate_rst_ovf", int'(overflow), 0);
    repeat (G + 20) @(negedge clk);
    chk("after_rst_busy", int'(busy), 0);

    // a fresh measurement works after the abort
    run_one(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
